axi4_write_arbiter: RTL

- Shares one AXI4-style write slave (AW/W/B channels, 1-bit bresp, no IDs) between two write masters, e.g. two multiplier-operand writers.
- Uses transaction-level round-robin. The grant is held from AW acceptance through the B handshake, so bursts never interleave.
- Sits between the master wrappers and the single slave port. It also reports the current grant and a sticky protocol-error flag.

---
 rtl/axi4_arb_pkg.sv | 17 +
 rtl/axi4_rr_pick.sv | 20 ++
 rtl/axi4_write_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared types for the two-master AXI4 write arbiter: FSM states and one-hot owner encodings.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef logic [1:0] owner_t;

  localparam owner_t GRANT_NONE = 2'b00;
  localparam owner_t GRANT_M0   = 2'b01;
  localparam owner_t GRANT_M1   = 2'b10;

endpackage

// File: rtl/axi4_rr_pick.sv
// Two-requester round-robin chooser; prio names the master that wins a tie.
module axi4_rr_pick
  import axi4_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output owner_t     pick
);

  always_comb begin
    pick = GRANT_NONE;
    case (req)
      2'b01:   pick = GRANT_M0;
      2'b10:   pick = GRANT_M1;
      2'b11:   pick = prio ? GRANT_M1 : GRANT_M0;
      default: pick = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/axi4_write_arbiter.sv
// Transaction-level round-robin arbiter sharing one AXI4 write slave between two masters;
// the grant is held from AW acceptance through the B handshake so bursts never interleave.
module axi4_write_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int ASZ    = 2,
  parameter int DSZ    = 8,
  parameter int MAXLEN = 4
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic [ASZ-1:0] m0_awaddr,
  input  logic           m0_awvalid,
  output logic           m0_awready,
  input  logic [DSZ-1:0] m0_wdata,
  input  logic           m0_wvalid,
  input  logic           m0_wlast,
  output logic           m0_wready,
  output logic           m0_bresp,
  output logic           m0_bvalid,
  input  logic           m0_bready,
  input  logic [ASZ-1:0] m1_awaddr,
  input  logic           m1_awvalid,
  output logic           m1_awready,
  input  logic [DSZ-1:0] m1_wdata,
  input  logic           m1_wvalid,
  input  logic           m1_wlast,
  output logic           m1_wready,
  output logic           m1_bresp,
  output logic           m1_bvalid,
  input  logic           m1_bready,
  output logic [ASZ-1:0] s_awaddr,
  output logic           s_awvalid,
  input  logic           s_awready,
  output logic [DSZ-1:0] s_wdata,
  output logic           s_wvalid,
  output logic           s_wlast,
  input  logic           s_wready,
  input  logic           s_bresp,
  input  logic           s_bvalid,
  output logic           s_bready,
  output logic [1:0]     grant,
  output logic           err
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAXLEN - 1);

  state_t        state_q, state_d;
  owner_t        grant_q, grant_d;
  owner_t        pick;
  logic          prio_q, prio_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          err_q, err_d;

  logic [ASZ-1:0] sel_awaddr;
  logic [DSZ-1:0] sel_wdata;
  logic           sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic           aw_hs, w_hs, b_hs, force_last;

  axi4_rr_pick u_pick (
    .req  ({m1_awvalid, m0_awvalid}),
    .prio (prio_q),
    .pick (pick)
  );

  assign sel_awaddr  = grant_q[1] ? m1_awaddr  : m0_awaddr;
  assign sel_awvalid = grant_q[1] ? m1_awvalid : m0_awvalid;
  assign sel_wdata   = grant_q[1] ? m1_wdata   : m0_wdata;
  assign sel_wvalid  = grant_q[1] ? m1_wvalid  : m0_wvalid;
  assign sel_wlast   = grant_q[1] ? m1_wlast   : m0_wlast;
  assign sel_bready  = grant_q[1] ? m1_bready  : m0_bready;

  // A burst that reaches MAXLEN without wlast is cut off on that beat.
  assign force_last = (beat_q == LAST_CNT);
  assign aw_hs = (state_q == ADDR) && sel_awvalid && s_awready;
  assign w_hs  = (state_q == DATA) && sel_wvalid && s_wready;
  assign b_hs  = (state_q == RESP) && s_bvalid && sel_bready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick != GRANT_NONE) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_d = beat_q + CW'(1);
          if (sel_wlast) begin
            state_d = RESP;
          end else if (force_last) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
          prio_d  = grant_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      prio_q  <= 1'b0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Each channel reaches the slave only in its own state; everything else idles at zero.
  always_comb begin
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wvalid   = 1'b0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    m0_bresp   = 1'b0;
    m1_bresp   = 1'b0;
    case (state_q)
      ADDR: begin
        s_awaddr   = sel_awaddr;
        s_awvalid  = sel_awvalid;
        m0_awready = grant_q[0] & s_awready;
        m1_awready = grant_q[1] & s_awready;
      end
      DATA: begin
        s_wdata   = sel_wdata;
        s_wvalid  = sel_wvalid;
        s_wlast   = sel_wlast | force_last;
        m0_wready = grant_q[0] & s_wready;
        m1_wready = grant_q[1] & s_wready;
      end
      RESP: begin
        s_bready  = sel_bready;
        m0_bvalid = grant_q[0] & s_bvalid;
        m1_bvalid = grant_q[1] & s_bvalid;
        m0_bresp  = grant_q[0] & s_bresp;
        m1_bresp  = grant_q[1] & s_bresp;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign err   = err_q;

endmodule
